// File: rtl/sym_fir_tdm.sv
// sym_fir_tdm: NCH-channel time-multiplexed symmetric FIR (one pre-adder, one multiplier, loadable taps); define SYM_FIR_SAT_EN to saturate m_data.
// Result valid HTAP+1 cycles after the input handshake; s_ready stays low until m_ready takes the result.
module sym_fir_tdm #(
  parameter int TAP    = 8,
  parameter int NCH    = 2,
  parameter int XIN_W  = 16,
  parameter int COE_W  = 16,
  parameter int ACC_W  = 48,
  parameter int YOUT_W = 26,
  parameter int SHIFT  = 0,
  localparam int HTAP  = TAP / 2,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int KA_W  = (HTAP > 1) ? $clog2(HTAP) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [XIN_W-1:0]  s_data,
  input  logic [CH_W-1:0]   s_chan,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [YOUT_W-1:0] m_data,
  output logic [CH_W-1:0]   m_chan,
  input  logic              coe_we,
  input  logic [KA_W-1:0]   coe_addr,
  input  logic [COE_W-1:0]  coe_data,
  output logic              busy,
  output logic              err
);

  localparam int TA_W = $clog2(TAP);
  localparam int P_W  = XIN_W + 1 + COE_W;
  localparam logic [KA_W-1:0] K_LAST = KA_W'(HTAP - 1);
  localparam logic [CH_W:0]   NCH_V  = (CH_W + 1)'(NCH);
  localparam logic signed [ACC_W-1:0] YMAX = {{(ACC_W-YOUT_W+1){1'b0}}, {(YOUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] YMIN = {{(ACC_W-YOUT_W+1){1'b1}}, {(YOUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state;
  logic signed [XIN_W-1:0]  xd [NCH][TAP];
  logic signed [COE_W-1:0]  h  [HTAP];
  logic signed [ACC_W-1:0]  acc;
  logic [CH_W-1:0]          ch;
  logic [KA_W-1:0]          k;

  logic [TA_W-1:0]          kr;
  logic signed [XIN_W-1:0]  xa, xb;
  logic signed [COE_W-1:0]  hk;
  logic signed [XIN_W:0]    pre;
  logic signed [P_W-1:0]    prod;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  shifted;
  logic [YOUT_W-1:0]        y;
  logic                     chan_ok;

  assign chan_ok = ({1'b0, s_chan} < NCH_V);

  // Mirrored tap pair shares one coefficient, so one pre-add feeds one multiply per cycle.
  always_comb begin
    kr      = TA_W'(TAP - 1) - TA_W'(k);
    xa      = xd[ch][k];
    xb      = xd[ch][kr];
    hk      = h[k];
    pre     = {xa[XIN_W-1], xa} + {xb[XIN_W-1], xb};
    prod    = P_W'(pre) * P_W'(hk);
    acc_nxt = acc + {{(ACC_W-P_W){prod[P_W-1]}}, prod};
    shifted = acc >>> SHIFT;
  end

`ifdef SYM_FIR_SAT_EN
  always_comb begin
    if (shifted > YMAX)
      y = YMAX[YOUT_W-1:0];
    else if (shifted < YMIN)
      y = YMIN[YOUT_W-1:0];
    else
      y = shifted[YOUT_W-1:0];
  end
`else
  logic unused_hi;
  assign y         = shifted[YOUT_W-1:0];
  assign unused_hi = ^{shifted[ACC_W-1:YOUT_W], YMAX, YMIN};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
      acc     <= '0;
      ch      <= '0;
      k       <= '0;
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < TAP; i++)
          xd[c][i] <= '0;
      for (int i = 0; i < HTAP; i++)
        h[i] <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (coe_we)
            h[coe_addr] <= coe_data;
          if (s_valid && s_ready) begin
            if (chan_ok) begin
              for (int i = TAP - 1; i > 0; i--)
                xd[s_chan][i] <= xd[s_chan][i-1];
              xd[s_chan][0] <= s_data;
              ch      <= s_chan;
              acc     <= '0;
              k       <= '0;
              s_ready <= 1'b0;
              busy    <= 1'b1;
              state   <= MAC;
            end else begin
              err <= 1'b1;
            end
          end
        end
        MAC: begin
          acc <= acc_nxt;
          k   <= k + 1'b1;
          if (k == K_LAST)
            state <= OUT;
        end
        OUT: begin
          // First OUT cycle registers the result; it then holds until taken.
          if (!m_valid) begin
            m_valid <= 1'b1;
            m_data  <= y;
            m_chan  <= ch;
          end else if (m_ready) begin
            m_valid <= 1'b0;
            busy    <= 1'b0;
            s_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sym_fir_tdm.sv
// Scoreboard bench for sym_fir_tdm with NCH=3: impulse, channel isolation, overflow, backpressure, bad channel, reset mid-MAC.
module tb_sym_fir_tdm;
  localparam int NCH  = 3;
  localparam int CH_W = 2;
  localparam int HTAP = 4;

  logic               clk = 1'b0;
  logic               rst_n, s_valid, s_ready, m_valid, m_ready, coe_we, busy, err;
  logic signed [15:0] s_data, coe_data;
  logic [CH_W-1:0]    s_chan, m_chan;
  logic signed [25:0] m_data;
  logic [1:0]         coe_addr;

  int     nvec = 0;
  int     nmis = 0;
  longint exp_d[$];
  int     exp_c[$];
  int     imp[8] = '{7, 14, -138, 129, 129, -138, 14, 7};
  int     c1[8]  = '{700, 2100, -11700, 1200, 14100, 300, 1700, 2400};

  always #5 clk = ~clk;

  sym_fir_tdm #(.NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_chan(s_chan),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan),
    .coe_we(coe_we), .coe_addr(coe_addr), .coe_data(coe_data),
    .busy(busy), .err(err)
  );

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_d.size() == 0)
        check("spurious_out", 1, 0);
      else begin
        check("m_data", m_data, exp_d.pop_front());
        check("m_chan", {1'b0, m_chan}, exp_c.pop_front());
      end
    end
  end

  task automatic load(input int a, input int v);
    coe_we   = 1'b1;
    coe_addr = a[1:0];
    coe_data = v[15:0];
    @(posedge clk); #1;
    coe_we = 1'b0;
  endtask

  task automatic send(input int ch, input int d, input bit push, input longint e, input bit wait_out);
    int n = 0;
    while (s_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check("s_ready_wait", s_ready, 1);
    s_valid = 1'b1;
    s_chan  = ch[CH_W-1:0];
    s_data  = d[15:0];
    if (push) begin exp_d.push_back(e); exp_c.push_back(ch); end
    @(posedge clk); #1;
    s_valid = 1'b0;
    if (wait_out) begin
      n = 0;
      while (m_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      check("latency", n, HTAP + 1);
      if (m_ready) begin @(posedge clk); #1; end
    end
  endtask

  task automatic reset_outs(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"},  m_data, 0);
    check({tag, "_m_chan"},  {1'b0, m_chan}, 0);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_err"},     err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    longint ovf;
    rst_n = 1'b0; s_valid = 1'b0; s_chan = '0; s_data = '0;
    m_ready = 1'b1; coe_we = 1'b0; coe_addr = '0; coe_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_outs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("s_ready_after_rst", s_ready, 1);

    // Impulse response on channel 0
    load(0, 7); load(1, 14); load(2, -138); load(3, 129);
    for (int i = 0; i < 8; i++)
      send(0, (i == 0) ? 1 : 0, 1, imp[i], 1);

    // Channel 0 impulse interleaved with channel 1 constant input
    for (int i = 0; i < 10; i++) begin
      if (i < 8) send(0, (i == 0) ? 1 : 0, 1, imp[i], 1);
      send(1, 100, 1, (i < 8) ? c1[i] : 2400, 1);
    end

    // Overflow on fresh channel 2: n-th output is n*32767^2 before narrowing
    for (int a = 0; a < 4; a++) load(a, 32767);
    for (int i = 1; i <= 8; i++) begin
`ifdef SYM_FIR_SAT_EN
      ovf = 33554431;
`else
      ovf = -65535 * i;
`endif
      send(2, 32767, 1, ovf, 1);
    end

    // Backpressure: result held, coefficient write ignored while busy
    for (int a = 0; a < 4; a++) load(a, a + 1);
    m_ready = 1'b0;
    send(0, 10, 1, 10, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_m_valid", m_valid, 1);
      check("bp_m_data", m_data, 10);
      check("bp_m_chan", {1'b0, m_chan}, 0);
      check("bp_s_ready", s_ready, 0);
      if (i == 1) begin coe_we = 1'b1; coe_addr = 2'd0; coe_data = 16'sd99; end
      @(posedge clk); #1;
      coe_we = 1'b0;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_m_valid_drop", m_valid, 0);
    send(1, 100, 1, 2000, 1);

    // Bad channel: dropped, err pulses once, no output, delay lines untouched
    s_valid = 1'b1; s_chan = 2'd3; s_data = 16'sd5555;
    @(posedge clk); #1;
    s_valid = 1'b0;
    check("bad_err_pulse", err, 1);
    check("bad_s_ready", s_ready, 1);
    @(posedge clk); #1;
    check("bad_err_clear", err, 0);
    n = 0;
    repeat (8) begin if (m_valid) n++; @(posedge clk); #1; end
    check("bad_no_out", n, 0);
    send(0, 0, 1, 20, 1);
    send(1, 100, 1, 2000, 1);

    // Reset at k=2 aborts; coefficients cleared afterwards
    send(0, 7, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    reset_outs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_s_ready", s_ready, 1);
    n = 0;
    repeat (10) begin if (m_valid) n++; @(posedge clk); #1; end
    check("midrst_no_out", n, 0);
    send(0, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) send(0, 0, 1, 0, 1);
    load(0, 7); load(1, 14); load(2, -138); load(3, 129);
    send(0, 0, 1, 129, 1);

    n = 0;
    while (exp_d.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    check("queue_empty", exp_d.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
